// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses, synchronous flush and a registered read port.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             pop_ok;
  logic             push_ok;

  // Acceptance: a pop frees a slot in the same edge, so a full FIFO can still take a push.
  always_comb begin
    pop_ok  = pop && !empty_q && !clear;
    push_ok = push && (!full_q || pop_ok) && !clear;
  end

  // Next-state for pointers, occupancy, read port and event pulses.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
      count_d     = count_q + CW'(push_ok) - CW'(pop_ok);
      overflow_d  = push && !push_ok;
      underflow_d = pop && !pop_ok;
    end
  end

  // Status flags precomputed from the next count so they are plain flops.
  always_comb begin
    full_d         = (count_d == CW'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CW'(AF_LEVEL));
    almost_empty_d = (count_d <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_LEVEL == 0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    dout         = dout_q;
    dout_valid   = dout_valid_q;
    full         = full_q;
    empty        = empty_q;
    almost_full  = almost_full_q;
    almost_empty = almost_empty_q;
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a queue-based model predicts every cycle's
// outputs; a separate monitor compares them and the popped data stream.
module tb_fifo_sync_param;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  fifo_sync_param #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .din(din),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    bit         full, empty, af, ae, ov, un, dv;
    logic [7:0] dout;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] model[$];
  logic [7:0] m_dout;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model's view of the edge is queued for the monitor.
  task automatic step(input bit r, input bit c, input bit pu, input bit po, input logic [7:0] d);
    exp_t e;
    bit   pop_ok, push_ok;
    rst = r; clear = c; push = pu; pop = po; din = d;
    e.ov = 0; e.un = 0; e.dv = 0;
    if (r) begin
      model.delete();
      m_dout = 8'h00;
    end else if (c) begin
      model.delete();
    end else begin
      pop_ok  = po && (model.size() > 0);
      push_ok = pu && (model.size() < DEPTH || pop_ok);
      if (pop_ok) begin
        m_dout = model.pop_front();
        data_q.push_back(m_dout);
      end
      if (push_ok) model.push_back(d);
      e.ov = pu && !push_ok;
      e.un = po && !pop_ok;
      e.dv = pop_ok;
    end
    e.cnt   = model.size();
    e.full  = (e.cnt == DEPTH);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= AF);
    e.ae    = (e.cnt <= AE);
    e.dout  = m_dout;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares status every cycle and popped words whenever dout_valid is seen.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("full", 32'(full), 32'(e.full));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("almost_empty", 32'(almost_empty), 32'(e.ae));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("underflow", 32'(underflow), 32'(e.un));
        chk("dout_valid", 32'(dout_valid), 32'(e.dv));
        chk("dout_hold", 32'(dout), 32'(e.dout));
        if (dout_valid === 1'b1) begin
          if (data_q.size() == 0) begin
            chk("unexpected_pop_data", 32'(dout), 32'hFFFF_FFFF);
          end else begin
            chk("pop_data", 32'(dout), 32'(data_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int unsigned pu_pct, po_pct;
    m_dout = 8'h00;
    // Reset for 4 cycles
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Fill to full, then one rejected push
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(8'h10 + i));
    step(0, 0, 1, 0, 8'hFF);
    step(0, 0, 0, 0, 8'h00);
    // Drain, then one rejected pop
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Fill, then simultaneous push+pop while full
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 8'(8'h80 + i));
    // Drain, then push+pop on empty
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 1, 8'h55);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // Flush with a push in the same cycle
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'(8'h20 + i));
    step(0, 0, 1, 0, 8'hAA);
    step(0, 1, 1, 1, 8'hBB);
    step(0, 0, 0, 1, 8'h00);
    // Reset mid-burst
    for (int i = 0; i < 5; i++) step(0, 0, 1, i[0], 8'(8'h40 + i));
    step(1, 0, 1, 1, 8'h99);
    step(0, 0, 0, 0, 8'h00);
    // Randomised traffic with phases biased towards full and towards empty
    for (int ph = 0; ph < 6; ph++) begin
      pu_pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      po_pct = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(199) == 0), ($urandom_range(79) == 0),
             ($urandom_range(99) < pu_pct), ($urandom_range(99) < po_pct),
             8'($urandom));
      end
    end
    step(0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #3;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("data_queue_drained", 32'(data_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
